// File: rtl/xy_mult_requester.sv
// xy_mult_requester
//   Bus-master sequencer for the memory-mapped xy multiplier slave.
//   It takes an operand pair over a valid/ready request port and writes X to
//   slave address 0 and Y to address 1. It then reads the product from
//   address 2 and returns it over a valid/ready result port.
//   An optional operand cache skips a write when the slave register already
//   holds the requested value.
// Ports
//   CLK, RST             clock (posedge) and synchronous active-high reset
//   REQ_VALID/READY      request handshake; REQ_X/REQ_Y are the operands
//   RES_VALID/READY      result handshake; RESULT is the captured product
//   BUS_E/W/R/ADDR/D     registered slave bus outputs
//   BUS_OUT              slave read data
module xy_mult_requester #(
  parameter int DATA_W    = 16,
  parameter int RES_W     = 32,
  parameter int READ_LAT  = 1,
  parameter int CACHE_OPS = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [DATA_W-1:0] REQ_X,
  input  logic [DATA_W-1:0] REQ_Y,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [RES_W-1:0]  RESULT,
  output logic              BUS_E,
  output logic              BUS_W,
  output logic              BUS_R,
  output logic [1:0]        BUS_ADDR,
  output logic [DATA_W-1:0] BUS_D,
  input  logic [RES_W-1:0]  BUS_OUT
);

  localparam int CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic CACHE_EN = (CACHE_OPS != 32'sd0);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR_X = 3'd1,
    ST_WR_Y = 3'd2,
    ST_RD   = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [DATA_W-1:0]   y_r, y_s;
  logic [DATA_W-1:0]   cache_x_r, cache_x_s, cache_y_r, cache_y_s;
  logic                cache_xv_r, cache_xv_s, cache_yv_r, cache_yv_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s, cnt_dec_s;
  logic                res_valid_r, res_valid_s;
  logic [RES_W-1:0]    result_r, result_s;
  logic                req_ready_r, req_ready_s;
  logic                bus_e_r, bus_e_s, bus_w_r, bus_w_s, bus_r_r, bus_r_s;
  logic [1:0]          bus_addr_r, bus_addr_s;
  logic [DATA_W-1:0]   bus_d_r, bus_d_s;
  logic                x_hit_req_s, y_hit_req_s, y_hit_lat_s;

  // Cache hit detection: against the incoming request and the latched Y.
  always_comb begin
    x_hit_req_s = CACHE_EN && cache_xv_r && (REQ_X == cache_x_r);
    y_hit_req_s = CACHE_EN && cache_yv_r && (REQ_Y == cache_y_r);
    y_hit_lat_s = CACHE_EN && cache_yv_r && (y_r == cache_y_r);
    cnt_dec_s   = cnt_r - CNT_ONE;
  end

  // Next-state and next-output logic for the bus sequencer.
  always_comb begin
    state_s     = state_r;
    y_s         = y_r;
    cache_x_s   = cache_x_r;
    cache_y_s   = cache_y_r;
    cache_xv_s  = cache_xv_r;
    cache_yv_s  = cache_yv_r;
    cnt_s       = cnt_r;
    res_valid_s = res_valid_r;
    result_s    = result_r;
    bus_e_s     = bus_e_r;
    bus_w_s     = bus_w_r;
    bus_r_s     = bus_r_r;
    bus_addr_s  = bus_addr_r;
    bus_d_s     = bus_d_r;

    // Result is only ever pending in IDLE, so the handshake is state-independent.
    if (res_valid_r && RES_READY) begin
      res_valid_s = 1'b0;
    end else begin
      res_valid_s = res_valid_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (REQ_VALID && req_ready_r) begin
          bus_e_s = 1'b1;
          y_s     = REQ_Y;
          if (!x_hit_req_s) begin
            state_s    = ST_WR_X;
            bus_addr_s = 2'd0;
            bus_d_s    = REQ_X;
            bus_w_s    = 1'b1;
            bus_r_s    = 1'b0;
          end else if (!y_hit_req_s) begin
            state_s    = ST_WR_Y;
            bus_addr_s = 2'd1;
            bus_d_s    = REQ_Y;
            bus_w_s    = 1'b1;
            bus_r_s    = 1'b0;
          end else begin
            state_s    = ST_RD;
            bus_addr_s = 2'd2;
            bus_w_s    = 1'b0;
            bus_r_s    = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_X: begin
        // The slave samples the X write on this edge, so the cache follows it.
        cache_x_s  = bus_d_r;
        cache_xv_s = CACHE_EN;
        if (y_hit_lat_s) begin
          state_s    = ST_RD;
          bus_addr_s = 2'd2;
          bus_w_s    = 1'b0;
          bus_r_s    = 1'b1;
        end else begin
          state_s    = ST_WR_Y;
          bus_addr_s = 2'd1;
          bus_d_s    = y_r;
          bus_w_s    = 1'b1;
          bus_r_s    = 1'b0;
        end
      end
      ST_WR_Y: begin
        cache_y_s  = bus_d_r;
        cache_yv_s = CACHE_EN;
        state_s    = ST_RD;
        bus_addr_s = 2'd2;
        bus_w_s    = 1'b0;
        bus_r_s    = 1'b1;
      end
      ST_RD: begin
        state_s = ST_WAIT;
        bus_w_s = 1'b0;
        bus_r_s = 1'b0;
        cnt_s   = CNT_LOAD;
      end
      ST_WAIT: begin
        // Capture lands READ_LAT edges after the slave sampled the read strobe.
        if (cnt_dec_s == CNT_ZERO) begin
          result_s    = BUS_OUT;
          res_valid_s = 1'b1;
          state_s     = ST_IDLE;
          cnt_s       = CNT_ZERO;
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      default: begin
        state_s = ST_IDLE;
        bus_w_s = 1'b0;
        bus_r_s = 1'b0;
      end
    endcase

    req_ready_s = (state_s == ST_IDLE) && !res_valid_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      y_r         <= {DATA_W{1'b0}};
      cache_x_r   <= {DATA_W{1'b0}};
      cache_y_r   <= {DATA_W{1'b0}};
      cache_xv_r  <= 1'b0;
      cache_yv_r  <= 1'b0;
      cnt_r       <= CNT_ZERO;
      res_valid_r <= 1'b0;
      result_r    <= {RES_W{1'b0}};
      req_ready_r <= 1'b0;
      bus_e_r     <= 1'b0;
      bus_w_r     <= 1'b0;
      bus_r_r     <= 1'b0;
      bus_addr_r  <= 2'd0;
      bus_d_r     <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      y_r         <= y_s;
      cache_x_r   <= cache_x_s;
      cache_y_r   <= cache_y_s;
      cache_xv_r  <= cache_xv_s;
      cache_yv_r  <= cache_yv_s;
      cnt_r       <= cnt_s;
      res_valid_r <= res_valid_s;
      result_r    <= result_s;
      req_ready_r <= req_ready_s;
      bus_e_r     <= bus_e_s;
      bus_w_r     <= bus_w_s;
      bus_r_r     <= bus_r_s;
      bus_addr_r  <= bus_addr_s;
      bus_d_r     <= bus_d_s;
    end
  end

  assign REQ_READY = req_ready_r;
  assign RES_VALID = res_valid_r;
  assign RESULT    = result_r;
  assign BUS_E     = bus_e_r;
  assign BUS_W     = bus_w_r;
  assign BUS_R     = bus_r_r;
  assign BUS_ADDR  = bus_addr_r;
  assign BUS_D     = bus_d_r;

endmodule
